uncached_bridge: RTL

UNCACHED_BRIDGE -- requirements
Module: uncached_bridge

---
 rtl/uncached_bridge_pkg.sv | 29 ++
 rtl/bridge_timer.sv | 30 +++
 rtl/uncached_bridge.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uncached_bridge_pkg.sv
// Shared definitions for the uncached access bridge: FSM encoding,
// access size codes and the alignment rule.
package uncached_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } bridge_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Reserved size code 3 is treated as misaligned so it is rejected locally.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'd0);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/bridge_timer.sv
// Transaction timeout counter: cleared on accept, counts busy cycles and
// flags when the allowed budget has been used up.
module bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [15:0] HIT_VAL = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Compare with >= so a grant won on the deadline still times out in WAIT.
  assign hit = (count >= HIT_VAL);

endmodule

// File: rtl/uncached_bridge.sv
// Bridge from the pipeline's uncached access port to the system bus:
// one outstanding transaction, local misalignment rejection, timeout abort.
module uncached_bridge
  import uncached_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  bridge_state_e state, state_next;
  logic          handshake;
  logic          timer_en;
  logic          timer_hit;
  logic          rsp_load;
  logic          rsp_err_next;
  logic [31:0]   rsp_rdata_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus events take priority over the timeout in the same cycle.
  always_comb begin
    state_next     = state;
    handshake      = 1'b0;
    timer_en       = 1'b0;
    rsp_load       = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          handshake = 1'b1;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_next   = ST_RESP;
            rsp_load     = 1'b1;
            rsp_err_next = 1'b1;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        timer_en = 1'b1;
        if (bus_gnt) begin
          state_next = ST_WAIT;
        end else if (timer_hit) begin
          state_next   = ST_RESP;
          rsp_load     = 1'b1;
          rsp_err_next = 1'b1;
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        if (bus_rvalid) begin
          state_next     = ST_RESP;
          rsp_load       = 1'b1;
          rsp_err_next   = bus_err;
          rsp_rdata_next = bus_rdata;
        end else if (timer_hit) begin
          state_next   = ST_RESP;
          rsp_load     = 1'b1;
          rsp_err_next = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_we    <= 1'b0;
      bus_size  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (handshake) begin
      bus_we    <= req_we;
      bus_size  <= req_size;
      bus_addr  <= req_addr;
      bus_wdata <= req_wdata;
      bus_wstrb <= req_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (rsp_load) begin
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (handshake),
    .enable (timer_en),
    .hit    (timer_hit)
  );

  assign req_ready = (state == ST_IDLE);
  assign bus_req   = (state == ST_REQ);
  assign rsp_valid = (state == ST_RESP);

endmodule
